csa_accum_ctrl: RTL
===================

Name: csa_accum_ctrl

Overview:
Sequencer for a shared 3:2 carry-save compressor that accumulates a stream of operands.
- Each accepted operand is folded into redundant sum/carry state, one operand per cycle.
- After the last operand, a carry-resolve phase iterates carry propagation until the carry vector is zero, then presents the binary result.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 4, operand width in bits
ACC_WIDTH, 8, accumulator/result width; must be >= WIDTH
CNT_W, 4, operand counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand
in_data  input  WIDTH  operand, unsigned, zero-extended to ACC_WIDTH
in_last  input  1  marks final operand of the group; qualified by handshake
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_WIDTH  resolved sum, modulo 2^ACC_WIDTH
out_count  output  CNT_W  operands accepted in group; saturates at 2^CNT_W-1
overflow  output  1  sticky per group: any carry lost beyond the MSB
busy  output  1  high in RESOLVE or DONE

Behaviour:
- Reset, checked on the clock edge:
  - state = ACCUM; internal S = 0, C = 0, count = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, overflow = 0, busy = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-group or mid-resolve discards all partial state, with no result emitted.
- States: ACCUM, RESOLVE, DONE.
- ACCUM:
  - in_ready = 1, busy = 0.
  - On accept (in_valid & in_ready), with D = zero-extended in_data:
    - S <= S ^ D ^ C
    - M = (S&D) | (S&C) | (D&C)
    - C <= M << 1, truncated to ACC_WIDTH
    - overflow <= overflow | M[ACC_WIDTH-1]
    - count <= count + 1, saturating
  - If in_last is accepted, go to RESOLVE; the current operand is included.
  - No accept: state holds.
- RESOLVE:
  - in_ready = 0, busy = 1.
  - Each cycle:
    - if C == 0: out_sum <= S, out_count <= count, out_valid <= 1, go to DONE.
    - else: S <= S ^ C, C <= (S & C) << 1, overflow <= overflow | (S&C)[ACC_WIDTH-1].
  - Iterations are at most ACC_WIDTH.
  - Latency from the last accept to out_valid is 1 + k cycles, where k = number of nonzero-C iterations.
- DONE:
  - out_valid = 1; out_sum, out_count and overflow are held stable until the handshake completes.
  - On out_valid & out_ready, in the same edge:
    - out_valid <= 0, clear S, C and count.
    - overflow is held visible until the next group's first accept, which restarts it at 0 before ORing in new carries.
    - Go to ACCUM.
  - in_ready remains 0 throughout DONE; there is no overlap between groups.
- A single-operand group (in_last on the first accept) is legal: result = operand, k = 0.
- out_count saturation does not affect the arithmetic; overflow reflects only lost carries.
- in_data and in_last are ignored when not accepted.
- out_ready is ignored outside DONE.

Test Plan:
1. Reset, then accept 3,5,7,9 (last on 9), out_ready = 1:
   - out_sum = 24, out_count = 4, overflow = 0.
   - out_valid rises exactly 1 + k cycles after the last accept; the bench checks k against a reference model.
2. Single operand 15 with in_last, out_ready = 1:
   - out_sum = 15, out_count = 1, out_valid exactly 1 cycle after accept.
3. 18 operands of 15, ACC_WIDTH = 8:
   - out_sum = 14 (270 mod 256), out_count = 15 (saturated), overflow = 1.
4. Backpressure: result ready, out_ready held 0 for 5 cycles:
   - out_valid, out_sum and out_count stay stable; in_ready = 0.
   - After out_ready = 1 for one cycle: in_ready = 1 next cycle, and the next group 1,1 gives out_sum = 2, overflow = 0.
5. Gapped input: in_valid toggling 1,0,0,1,1 with operands 10,4,6 (last on 6):
   - No state change on idle cycles; out_sum = 20.
6. Reset asserted during RESOLVE of a group of 15,15,15:
   - Next cycle: out_valid = 0, in_ready = 1.
   - A new group 2 (last) yields out_sum = 2, out_count = 1, with no leftover state.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csa_accum_ctrl
//  Description : Sequencer for a shared 3:2 carry-save compressor. Operands
//                arriving over a valid/ready handshake are folded into a
//                redundant sum/carry pair (S, C), one operand per cycle. After
//                the operand flagged as last, a resolve phase repeatedly
//                half-adds C into S until C is zero. The binary result is
//                then held on a valid/ready output until the consumer takes it.
//
//  Ports       :
//      clk        in   1          rising-edge clock
//      rst        in   1          synchronous reset, active-high
//      in_valid   in   1          operand valid
//      in_ready   out  1          block can accept an operand (ACCUM only)
//      in_data    in   WIDTH      unsigned operand, zero-extended
//      in_last    in   1          final operand of the group
//      out_valid  out  1          result valid
//      out_ready  in   1          consumer accepts result
//      out_sum    out  ACC_WIDTH  resolved sum, modulo 2^ACC_WIDTH
//      out_count  out  CNT_W      operands accepted in group (saturating)
//      overflow   out  1          a carry was lost beyond the MSB this group
//      busy       out  1          high in RESOLVE or DONE
//
//  Revision    : 1.0  initial release
// ============================================================================
module csa_accum_ctrl #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 overflow,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_ACCUM   = 2'd0;
    localparam logic [1:0] c_ST_RESOLVE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [ACC_WIDTH-1:0] r_s;
    logic [ACC_WIDTH-1:0] r_c;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_sum;
    logic [CNT_W-1:0]     r_out_count;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_done_hs;
    logic [ACC_WIDTH-1:0] w_d;
    logic [ACC_WIDTH-1:0] w_csa_sum;
    logic [ACC_WIDTH-1:0] w_csa_maj;
    logic [ACC_WIDTH-1:0] w_res_gen;
    logic                 w_c_zero;
    logic                 w_first_accept;
    logic                 w_count_sat;

    assign w_accept  = in_valid && (r_state == c_ST_ACCUM);
    assign w_done_hs = r_out_valid && out_ready && (r_state == c_ST_DONE);
    assign w_d       = ACC_WIDTH'(in_data);

    // 3:2 compressor: bitwise full adder across S, D and C
    assign w_csa_sum = r_s ^ w_d ^ r_c;
    assign w_csa_maj = (r_s & w_d) | (r_s & r_c) | (w_d & r_c);

    // Resolve step is a half adder of S and C; its generate bits become the
    // next carry vector
    assign w_res_gen = r_s & r_c;
    assign w_c_zero  = (r_c == '0);

    // count is only zero on the first accept of a group: it is cleared by
    // reset and by the result handshake, and never wraps (it saturates)
    assign w_first_accept = (r_count == '0);
    assign w_count_sat    = &r_count;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [1:0]           w_state_nxt;
    logic [ACC_WIDTH-1:0] w_s_nxt;
    logic [ACC_WIDTH-1:0] w_c_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_overflow_nxt;
    logic                 w_out_valid_nxt;
    logic [ACC_WIDTH-1:0] w_out_sum_nxt;
    logic [CNT_W-1:0]     w_out_count_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_c_nxt         = r_c;
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_count_nxt = r_out_count;

        case (r_state)
            c_ST_ACCUM: begin
                if (w_accept) begin
                    w_s_nxt     = w_csa_sum;
                    w_c_nxt     = w_csa_maj << 1;
                    w_count_nxt = w_count_sat ? r_count : r_count + 1'b1;
                    // Previous group's flag stays visible until this point
                    w_overflow_nxt = (w_first_accept ? 1'b0 : r_overflow)
                                     | w_csa_maj[ACC_WIDTH-1];
                    if (in_last) begin
                        w_state_nxt = c_ST_RESOLVE;
                    end
                end
            end

            c_ST_RESOLVE: begin
                if (w_c_zero) begin
                    w_out_sum_nxt   = r_s;
                    w_out_count_nxt = r_count;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = c_ST_DONE;
                end else begin
                    w_s_nxt        = r_s ^ r_c;
                    w_c_nxt        = w_res_gen << 1;
                    w_overflow_nxt = r_overflow | w_res_gen[ACC_WIDTH-1];
                end
            end

            c_ST_DONE: begin
                if (w_done_hs) begin
                    w_out_valid_nxt = 1'b0;
                    w_s_nxt         = '0;
                    w_c_nxt         = '0;
                    w_count_nxt     = '0;
                    w_state_nxt     = c_ST_ACCUM;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle group
                w_state_nxt     = c_ST_ACCUM;
                w_s_nxt         = '0;
                w_c_nxt         = '0;
                w_count_nxt     = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_ACCUM;
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_c         <= w_c_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_count <= w_out_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == c_ST_ACCUM);
    assign busy      = (r_state == c_ST_RESOLVE) || (r_state == c_ST_DONE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
